// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Opcode, ALU operation and phase encodings shared by the controller
//            and the ALU of the 8-bit CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int OPW    = 3;
   localparam int NPHASE = 8;

   localparam logic [OPW-1:0] OP_HLT = 3'd0;
   localparam logic [OPW-1:0] OP_SKZ = 3'd1;
   localparam logic [OPW-1:0] OP_ADD = 3'd2;
   localparam logic [OPW-1:0] OP_AND = 3'd3;
   localparam logic [OPW-1:0] OP_XOR = 3'd4;
   localparam logic [OPW-1:0] OP_LDA = 3'd5;
   localparam logic [OPW-1:0] OP_STO = 3'd6;
   localparam logic [OPW-1:0] OP_JMP = 3'd7;

   localparam logic [2:0] ALU_PASSA = 3'd0;
   localparam logic [2:0] ALU_ADD   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_XOR   = 3'd3;
   localparam logic [2:0] ALU_PASSB = 3'd4;

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_EXEC   = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   // Opcodes that read a memory operand into the ALU
   function automatic logic is_aluop(input logic [OPW-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
// ============================================================================
// Module   : cpu_ctrl_decode
// Brief    : Combinational strobe and ALU_OP decode from phase, opcode, zero
//            flag and halt state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl_decode
   import cpu_pkg::*;
(
   input  phase_e         phase_i,
   input  logic [OPW-1:0] opcode_i,
   input  logic           skz_cmp_i,
   input  logic           halt_i,
   output logic [2:0]     alu_op_o,
   output logic           sel_o,
   output logic           rd_o,
   output logic           ld_ir_o,
   output logic           inc_pc_o,
   output logic           ld_pc_o,
   output logic           ld_ac_o,
   output logic           wr_o,
   output logic           data_e_o
);

   logic w_aluop;
   logic w_jmp;
   logic w_sto;
   logic w_skz;

   assign w_aluop = is_aluop(opcode_i);
   assign w_jmp   = (opcode_i == OP_JMP);
   assign w_sto   = (opcode_i == OP_STO);
   assign w_skz   = (opcode_i == OP_SKZ);

   always_comb begin
      alu_op_o = ALU_PASSA;
      case (opcode_i)
         OP_ADD:  alu_op_o = ALU_ADD;
         OP_AND:  alu_op_o = ALU_AND;
         OP_XOR:  alu_op_o = ALU_XOR;
         OP_LDA:  alu_op_o = ALU_PASSB;
         default: alu_op_o = ALU_PASSA;
      endcase
   end

   always_comb begin
      sel_o    = 1'b0;
      rd_o     = 1'b0;
      ld_ir_o  = 1'b0;
      inc_pc_o = 1'b0;
      ld_pc_o  = 1'b0;
      ld_ac_o  = 1'b0;
      wr_o     = 1'b0;
      data_e_o = 1'b0;
      case (phase_i)
         PH_INST_ADDR: sel_o = 1'b1;
         PH_INST_FETCH: begin
            sel_o = 1'b1;
            rd_o  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel_o   = 1'b1;
            rd_o    = 1'b1;
            ld_ir_o = 1'b1;
         end
         PH_OP_ADDR:  inc_pc_o = 1'b1;
         PH_OP_FETCH: rd_o     = w_aluop;
         PH_ALU_EXEC: begin
            rd_o     = w_aluop;
            inc_pc_o = w_skz & skz_cmp_i;
            ld_pc_o  = w_jmp;
            data_e_o = w_sto;
         end
         PH_STORE: begin
            rd_o     = w_aluop;
            ld_ac_o  = w_aluop;
            ld_pc_o  = w_jmp;
            wr_o     = w_sto;
            data_e_o = w_sto;
         end
         default: ;
      endcase
      // A halted CPU must leave memory, PC and ACC untouched
      if (halt_i) begin
         sel_o    = 1'b0;
         rd_o     = 1'b0;
         ld_ir_o  = 1'b0;
         inc_pc_o = 1'b0;
         ld_pc_o  = 1'b0;
         ld_ac_o  = 1'b0;
         wr_o     = 1'b0;
         data_e_o = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module   : cpu_controller
// Brief    : 8-phase fetch/execute sequencer; holds the phase counter and the
//            sticky halt flag, strobes come from cpu_ctrl_decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_controller
   import cpu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [OPW-1:0] opcode,
   input  logic           SKZ_cmp,
   output logic [2:0]     ALU_OP,
   output logic           sel,
   output logic           rd,
   output logic           ld_ir,
   output logic           inc_pc,
   output logic           ld_pc,
   output logic           ld_ac,
   output logic           wr,
   output logic           data_e,
   output logic           halt,
   output logic [2:0]     phase
);

   phase_e     phase_q;
   phase_e     phase_d;
   logic       halt_q;
   logic       halt_d;
   logic [2:0] w_phase_inc;

   assign w_phase_inc = phase_q + 3'd1;

   always_comb begin
      phase_d = phase_q;
      halt_d  = halt_q;
      if (en && !halt_q) begin
         phase_d = phase_e'(w_phase_inc);
         // Halting on the edge out of OP_ADDR leaves the phase parked at OP_FETCH
         if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            halt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_INST_ADDR;
         halt_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         halt_q  <= halt_d;
      end
   end

   assign phase = phase_q;
   assign halt  = halt_q;

   cpu_ctrl_decode u_decode (
      .phase_i   (phase_q),
      .opcode_i  (opcode),
      .skz_cmp_i (SKZ_cmp),
      .halt_i    (halt_q),
      .alu_op_o  (ALU_OP),
      .sel_o     (sel),
      .rd_o      (rd),
      .ld_ir_o   (ld_ir),
      .inc_pc_o  (inc_pc),
      .ld_pc_o   (ld_pc),
      .ld_ac_o   (ld_ac),
      .wr_o      (wr),
      .data_e_o  (data_e)
   );

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module   : tb_cpu_controller
// Brief    : Directed self-checking bench for the cpu_controller sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_controller;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] opcode;
   logic       SKZ_cmp;
   logic [2:0] ALU_OP;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   int n_checks = 0;
   int n_pass   = 0;

   cpu_controller dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .opcode  (opcode),
      .SKZ_cmp (SKZ_cmp),
      .ALU_OP  (ALU_OP),
      .sel     (sel),
      .rd      (rd),
      .ld_ir   (ld_ir),
      .inc_pc  (inc_pc),
      .ld_pc   (ld_pc),
      .ld_ac   (ld_ac),
      .wr      (wr),
      .data_e  (data_e),
      .halt    (halt),
      .phase   (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
   logic [7:0] w_str;
   assign w_str = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [7:0] exp_strobes(input int p, input logic [2:0] op, input logic cmp);
      logic a, j, s, k;
      a = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      j = (op == 3'd7);
      s = (op == 3'd6);
      k = (op == 3'd1);
      case (p)
         0:       return 8'b1000_0000;
         1:       return 8'b1100_0000;
         2, 3:    return 8'b1110_0000;
         4:       return 8'b0001_0000;
         5:       return {1'b0, a, 6'b0};
         6:       return {1'b0, a, 1'b0, k & cmp, j, 2'b00, s};
         default: return {1'b0, a, 2'b00, j, a, s, s};
      endcase
   endfunction

   function automatic logic [2:0] exp_alu(input logic [2:0] op);
      case (op)
         3'd2:    return 3'd1;
         3'd3:    return 3'd2;
         3'd4:    return 3'd3;
         3'd5:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   task automatic check_phase(input int p, input logic [2:0] op, input logic cmp);
      check($sformatf("phase op%0d p%0d", op, p), {29'd0, phase}, p);
      check($sformatf("strobes op%0d p%0d", op, p), {24'd0, w_str}, {24'd0, exp_strobes(p, op, cmp)});
      check($sformatf("alu_op op%0d p%0d", op, p), {29'd0, ALU_OP}, {29'd0, exp_alu(op)});
      check($sformatf("halt op%0d p%0d", op, p), {31'd0, halt}, 32'd0);
   endtask

   // Walks phases 0..stop_p starting from phase 0; SKZ_cmp is inverted outside
   // ALU_EXEC so only the ALU_EXEC value may influence inc_pc.
   task automatic run_instr(input logic [2:0] op, input logic cmp, input int stall_p, input int stop_p);
      for (int p = 0; p <= stop_p; p++) begin
         opcode  = op;
         SKZ_cmp = (p == 6) ? cmp : ~cmp;
         #1;
         check_phase(p, op, cmp);
         if (p == stall_p) begin
            en = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(posedge clk); #1;
               check_phase(p, op, cmp);
            end
            en = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      opcode  = 3'd0;
      SKZ_cmp = 1'b0;
      @(negedge clk);
      check("reset phase", {29'd0, phase}, 32'd0);
      check("reset halt", {31'd0, halt}, 32'd0);
      check("reset strobes", {24'd0, w_str}, 32'h80);
      check("reset alu_op", {29'd0, ALU_OP}, 32'd0);
      rst = 1'b0;

      run_instr(3'd2, 1'b0, -1, 7);      // ADD
      run_instr(3'd1, 1'b1, -1, 7);      // SKZ, zero
      run_instr(3'd1, 1'b0, -1, 7);      // SKZ, non-zero
      run_instr(3'd6, 1'b0, -1, 7);      // STO
      run_instr(3'd7, 1'b1, -1, 7);      // JMP
      run_instr(3'd3, 1'b0, -1, 7);      // AND
      run_instr(3'd4, 1'b1, -1, 7);      // XOR
      run_instr(3'd5, 1'b0, 2, 7);       // LDA with en stall in INST_LOAD

      // HLT, with an en stall in OP_ADDR that must not set halt
      run_instr(3'd0, 1'b0, 4, 4);
      check("halt set", {31'd0, halt}, 32'd1);
      check("halt phase", {29'd0, phase}, 32'd5);
      check("halt strobes", {24'd0, w_str}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         SKZ_cmp = i[0];
         @(posedge clk); #1;
         check($sformatf("halted phase c%0d", i), {29'd0, phase}, 32'd5);
         check($sformatf("halted strobes c%0d", i), {24'd0, w_str}, 32'd0);
         check($sformatf("halted flag c%0d", i), {31'd0, halt}, 32'd1);
      end
      #2 rst = 1'b1;
      #1;
      check("hlt rst phase", {29'd0, phase}, 32'd0);
      check("hlt rst halt", {31'd0, halt}, 32'd0);
      check("hlt rst strobes", {24'd0, w_str}, 32'h80);
      @(negedge clk);
      rst = 1'b0;

      // STO aborted by asynchronous reset in STORE
      run_instr(3'd6, 1'b0, -1, 6);
      check("sto p7 phase", {29'd0, phase}, 32'd7);
      check("sto p7 wr", {31'd0, wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort wr", {31'd0, wr}, 32'd0);
      check("abort phase", {29'd0, phase}, 32'd0);
      check("abort strobes", {24'd0, w_str}, 32'h80);
      @(negedge clk);
      rst = 1'b0;
      run_instr(3'd2, 1'b0, -1, 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
